// File: rtl/disp_value_gen.sv
// -----------------------------------------------------------------------------
// disp_value_gen
//
// Value source for the 8-digit seven-segment display. It owns the 32-bit value
// shown on the hex digits and a per-digit leading-zero blank mask. A bouncy
// push-button is synchronised and debounced into single step pulses. The value
// counts up or down with wrap-around, and can be parallel-loaded.
//
// Optional feature (macro AUTO_INC_EN):
//   When defined, a free-running divider adds a periodic auto-step every
//   AUTO_DIV clocks. The auto-step is ORed with the button step.
//   When undefined, no divider exists and AUTO_DIV is ignored.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or release (>= 2)
//   AUTO_DIV         auto-step period in clocks, AUTO_INC_EN builds only (>= 2)
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   step_btn  in   raw push-button (asynchronous, bouncy), 1 = pressed
//   up_dn     in   raw direction switch (asynchronous), 1 = up, 0 = down
//   load      in   synchronous load strobe, has priority over stepping
//   load_val  in   value written on load
//   Value     out  displayed value, nibble i -> digit i (digit 0 rightmost)
//   Blank     out  1 = digit blanked as a leading zero, Blank[0] always 0
//   Update    out  one-cycle pulse aligned with every new Value
// -----------------------------------------------------------------------------
module disp_value_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_DIV        = 100000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step_btn,
    input  logic        up_dn,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] Value,
    output logic [7:0]  Blank,
    output logic        Update
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        QUAL_PRESS,
        HELD,
        QUAL_REL
    } deb_state_t;

    // ---------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous button and switch
    // ---------------------------------------------------------------
    logic [1:0] btn_sync_reg;
    logic [1:0] up_sync_reg;
    logic       btn_s;
    logic       up_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_sync_reg <= '0;
            up_sync_reg  <= '0;
        end else begin
            btn_sync_reg <= {btn_sync_reg[0], step_btn};
            up_sync_reg  <= {up_sync_reg[0], up_dn};
        end
    end

    assign btn_s = btn_sync_reg[1];
    assign up_s  = up_sync_reg[1];

    // ---------------------------------------------------------------
    // Debounce FSM. A press is accepted only after the synchronised
    // button has stayed high through a full qualification window. A
    // release must likewise qualify before a new press is looked for.
    // Holding the button therefore never repeats.
    // ---------------------------------------------------------------
    deb_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             step_p;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (btn_s) begin
                        state_reg <= QUAL_PRESS;
                        count_reg <= '0;
                    end
                end
                QUAL_PRESS: begin
                    if (!btn_s) begin
                        state_reg <= IDLE;
                    end else if (count_reg == CNT_LAST) begin
                        state_reg <= HELD;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_reg <= QUAL_REL;
                        count_reg <= '0;
                    end
                end
                QUAL_REL: begin
                    if (btn_s) begin
                        state_reg <= HELD;
                    end else if (count_reg == CNT_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The step is decoded from the qualifying cycle itself. This lets the
    // value register capture it on the same edge that moves the FSM to HELD.
    assign step_p = (state_reg == QUAL_PRESS) && btn_s && (count_reg == CNT_LAST);

    // ---------------------------------------------------------------
    // Optional periodic auto-step
    // ---------------------------------------------------------------
    logic auto_p;

`ifdef AUTO_INC_EN
    localparam int DIV_W = $clog2(AUTO_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

    logic [DIV_W-1:0] div_reg;

    // Free-running divider. A load does not disturb its phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    assign auto_p = (div_reg == DIV_LAST);
`else
    logic unused_auto_div;

    assign auto_p          = 1'b0;
    assign unused_auto_div = (AUTO_DIV > 1);
`endif

    // ---------------------------------------------------------------
    // Value counter and blank mask.
    // Load beats a step; a step that collides with a load is dropped.
    // ---------------------------------------------------------------
    logic [31:0] value_reg;
    logic [31:0] value_next;
    logic [7:0]  blank_reg;
    logic [7:0]  blank_next;
    logic        update_reg;
    logic        update_next;

    always_comb begin
        value_next  = value_reg;
        update_next = 1'b0;
        if (load) begin
            value_next  = load_val;
            update_next = 1'b1;
        end else if (step_p || auto_p) begin
            value_next  = up_s ? (value_reg + 32'd1) : (value_reg - 32'd1);
            update_next = 1'b1;
        end
    end

    // The mask is built from value_next so it lands in the same cycle as
    // the value it describes. Digit i blanks only when it and every more
    // significant digit are zero.
    assign blank_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_blank
            assign blank_next[gi] = ~|value_next[31:4*gi];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_reg  <= 32'h0;
            blank_reg  <= 8'hFE;
            update_reg <= 1'b0;
        end else begin
            value_reg  <= value_next;
            blank_reg  <= blank_next;
            update_reg <= update_next;
        end
    end

    assign Value  = value_reg;
    assign Blank  = blank_reg;
    assign Update = update_reg;

endmodule

// File: tb/tb_disp_value_gen.sv
// -----------------------------------------------------------------------------
// tb_disp_value_gen
//
// Checks disp_value_gen (DEBOUNCE_CYCLES=4) against a behavioural model. The
// model treats the debouncer as "the accepted button level flips once the
// synchronised input has disagreed with it for DEB+1 consecutive cycles".
// A flip to pressed produces one step.
// Directed scenarios come first, followed by a randomized run with bounces,
// loads, direction changes and reset pulses. Outputs are compared on every
// falling edge.
// -----------------------------------------------------------------------------
module tb_disp_value_gen;

    localparam int DEB = 4;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        step_btn = 1'b0;
    logic        up_dn    = 1'b0;
    logic        load     = 1'b0;
    logic [31:0] load_val = 32'h0;
    logic [31:0] Value;
    logic [7:0]  Blank;
    logic        Update;

    int checks       = 0;
    int failures     = 0;
    int updates_seen = 0;

    // Reference model state
    bit          m_s1, m_s2, m_u1, m_u2;
    bit          m_acc;
    int          m_run;
    logic [31:0] exp_value;
    logic [7:0]  exp_blank;
    bit          exp_update;

    disp_value_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_DIV       (10)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .step_btn(step_btn),
        .up_dn   (up_dn),
        .load    (load),
        .load_val(load_val),
        .Value   (Value),
        .Blank   (Blank),
        .Update  (Update)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] blank_of(input logic [31:0] v);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 1; i < 8; i++) begin
            b[i] = ((v >> (4 * i)) == 32'd0);
        end
        return b;
    endfunction

    // True when the current cycle is the one in which a press gets accepted.
    function automatic bit step_now();
        return m_s2 && !m_acc && (m_run + 1 == DEB + 1);
    endfunction

    task automatic model_reset();
        m_s1       = 1'b0;
        m_s2       = 1'b0;
        m_u1       = 1'b0;
        m_u2       = 1'b0;
        m_acc      = 1'b0;
        m_run      = 0;
        exp_value  = 32'h0;
        exp_blank  = 8'hFE;
        exp_update = 1'b0;
    endtask

    // Advance the model across one rising edge using this cycle's inputs.
    task automatic model_advance(input bit b, input bit u, input bit ld, input logic [31:0] lv);
        bit step;
        step = 1'b0;
        if (m_s2 != m_acc) m_run++;
        else m_run = 0;
        if (m_run == DEB + 1) begin
            step  = !m_acc;
            m_acc = !m_acc;
            m_run = 0;
        end
        if (ld) begin
            exp_value  = lv;
            exp_update = 1'b1;
        end else if (step) begin
            exp_value  = m_u2 ? exp_value + 32'd1 : exp_value - 32'd1;
            exp_update = 1'b1;
        end else begin
            exp_update = 1'b0;
        end
        exp_blank = blank_of(exp_value);
        m_s2 = m_s1;
        m_s1 = b;
        m_u2 = m_u1;
        m_u1 = u;
    endtask

    // One clock cycle: check the outputs on the falling edge, then drive the
    // new inputs and advance the model.
    task automatic tick(input bit b, input bit u, input bit ld, input logic [31:0] lv, input bit rn);
        @(negedge clock);
        check_val("value", Value, exp_value);
        check_val("blank", {24'h0, Blank}, {24'h0, exp_blank});
        check_val("update", {31'h0, Update}, {31'h0, exp_update});
        if (Update === 1'b1) begin
            updates_seen++;
            $display("txn t=%0t value=%h blank=%h", $time, Value, Blank);
        end
        step_btn = b;
        up_dn    = u;
        load     = ld;
        load_val = lv;
        reset    = rn;
        if (!rn) model_reset();
        else model_advance(b, u, ld, lv);
    endtask

    task automatic press(input bit u);
        repeat (10) tick(1'b1, u, 1'b0, 32'h0, 1'b1);
        repeat (10) tick(1'b0, u, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic expect_now(input string tag, input logic [31:0] v, input logic [7:0] b);
        check_val(tag, Value, v);
        check_val({tag, "_blank"}, {24'h0, Blank}, {24'h0, b});
    endtask

    initial begin
        int u0;
        bit lvl;
        bit u;
        bit ld;
        bit rn;
        int seg;
        int rst_left;
        logic [31:0] lv;

        model_reset();

        // 1: reset held, then released
        repeat (5) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_now("t1_reset", 32'h0, 8'hFE);
        repeat (3) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_now("t1_idle", 32'h0, 8'hFE);

        // 2: bounces, then one clean press
        u0 = updates_seen;
        repeat (2) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (8) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_now("t2_bounce", 32'h0, 8'hFE);
        press(1'b1);
        expect_now("t2_press", 32'h1, 8'hFE);
        check_val("t2_updates", 32'(updates_seen - u0), 32'd1);

        // 3: load then step up across a nibble boundary
        tick(1'b0, 1'b1, 1'b1, 32'h0000FFFF, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_now("t3_load", 32'h0000FFFF, 8'hF0);
        press(1'b1);
        expect_now("t3_up", 32'h00010000, 8'hE0);

        // 4: wrap down and back up
        tick(1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        press(1'b0);
        expect_now("t4_down", 32'hFFFFFFFF, 8'h00);
        press(1'b1);
        expect_now("t4_up", 32'h0, 8'hFE);

        // 5: load coincident with the accepted step
        u0 = updates_seen;
        for (int i = 0; i < 20; i++) begin
            tick(i < 10, 1'b1, step_now(), 32'h12345678, 1'b1);
        end
        repeat (4) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_now("t5_collide", 32'h12345678, 8'h00);
        check_val("t5_updates", 32'(updates_seen - u0), 32'd1);

        // 6: reset during qualification, button released before requalifying
        u0 = updates_seen;
        repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (12) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_now("t6_abort", 32'h0, 8'hFE);
        check_val("t6_updates", 32'(updates_seen - u0), 32'd0);

        // 7: button held through reset release requalifies once
        repeat (2) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (12) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (10) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_now("t7_held", 32'h1, 8'hFE);

        // Randomized run
        lvl      = 1'b0;
        u        = 1'b1;
        seg      = 0;
        rst_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (seg == 0) begin
                lvl = !lvl;
                seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14));
                u   = ($urandom_range(0, 1) == 1);
            end
            seg--;
            ld = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 4))
                0:       lv = $urandom;
                1:       lv = 32'hFFFFFFFF;
                2:       lv = 32'h0;
                3:       lv = 32'hFFFFFFFE;
                default: lv = {28'h0, 4'($urandom_range(0, 15))};
            endcase
            if (rst_left == 0 && $urandom_range(0, 399) == 0) begin
                rst_left = int'($urandom_range(1, 3));
            end
            rn = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            tick(lvl, u, ld, lv, rn);
        end
        repeat (3) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
